// File: rtl/result_encoder_master.sv
// Serial transmitter for ALU results: frames {result, flags, oper, parity} as an
// 11-bit word behind a start bit and ahead of a stop bit, MSB first.
module result_encoder_master #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] result,
    input  logic [3:0] flags,
    input  logic [1:0] oper,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned FRAME_W = 11;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned IDX_W   = 4;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [FRAME_W-1:0]   frame_c;
    logic                 bit_end_c;
    logic [IDX_W-1:0]     idx_dec_c;

    // Parity over the ten payload bits keeps the whole word at even parity.
    assign frame_c   = {result, flags, oper, ^{result, flags, oper}};
    assign bit_end_c = (cnt_q == BIT_LAST);
    assign idx_dec_c = idx_q - IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // tx/busy/done are computed one cycle early so the registered outputs line
    // up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    frame_d = frame_c;
                    state_d = START_BIT;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START_BIT: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    idx_d   = FIRST_IDX;
                    tx_d    = frame_q[FIRST_IDX];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        tx_d    = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        idx_d = idx_dec_c;
                        tx_d  = frame_q[idx_dec_c];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP_BIT: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_result_encoder_master.sv
// Self-checking bench for result_encoder_master: frame timing, parity, start
// filtering, back-to-back frames, async reset abort and random frames.
module tb_result_encoder_master;

    localparam int C  = 4;
    localparam int FL = 13 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] result = '0;
    logic [3:0] flags = '0;
    logic [1:0] oper = '0;
    logic       tx, busy, done;

    int total = 0;
    int bad   = 0;

    logic tx_s   [0:399];
    logic busy_s [0:399];
    logic done_s [0:399];

    result_encoder_master #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .start(start), .result(result), .flags(flags),
        .oper(oper), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_word(input logic [3:0] r, input logic [3:0] f,
                                             input logic [1:0] o);
        int ones;
        ones = $countones({r, f, o});
        return {r, f, o, 1'(ones % 2)};
    endfunction

    // Expected line level at cycle c (1-based) of a frame.
    function automatic logic exp_tx(input logic [10:0] w, input int c);
        int s;
        s = (c - 1) / C;
        if (s == 0) return 1'b0;
        if (s >= 12) return 1'b1;
        return w[11 - s];
    endfunction

    // Mid-bit receiver over captured samples; base is the first start-bit sample.
    function automatic logic [10:0] rx_word(input int base);
        logic [10:0] w;
        for (int s = 1; s <= 11; s++) w[11 - s] = tx_s[base + s * C + C / 2];
        return w;
    endfunction

    task automatic launch(input logic [3:0] r, input logic [3:0] f, input logic [1:0] o);
        result = r;
        flags  = f;
        oper   = o;
        start  = 1'b1;
    endtask

    // Samples outputs on n falling edges; optionally holds start or re-pulses it.
    task automatic capture(input int n, input bit hold, input int repulse);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!hold && i == 0) start = 1'b0;
            if (i == repulse) begin
                start  = 1'b1;
                result = 4'($urandom);
                flags  = 4'($urandom);
                oper   = 2'($urandom);
            end
            if (repulse >= 0 && i == repulse + 1) start = 1'b0;
            if (hold && i == n - 1) start = 1'b0;
            tx_s[i]   = tx;
            busy_s[i] = busy;
            done_s[i] = done;
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1)   begin bad++; $display("FAIL reset_tx: got %b exp 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b exp 0", done); end
        start = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++; $display("FAIL reset_hold: busy=%b tx=%b exp busy=0 tx=1", busy, tx);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: busy=%b tx=%b done=%b", busy, tx, done);
        end
    endtask

    task automatic test_known_frame;
        logic [12:0] seq;
        seq = 13'b0101001001111;
        launch(4'b1010, 4'b0100, 2'b11);
        capture(FL + 2, 1'b0, -1);
        for (int i = 0; i < FL; i++) begin
            total++; if (tx_s[i] !== seq[12 - i / C]) begin
                bad++; $display("FAIL known_tx[%0d]: got %b exp %b", i + 1, tx_s[i], seq[12 - i / C]);
            end
            total++; if (busy_s[i] !== 1'b1 || done_s[i] !== 1'b0) begin
                bad++; $display("FAIL known_busy[%0d]: busy=%b done=%b exp 1/0", i + 1, busy_s[i], done_s[i]);
            end
        end
        total++; if (done_s[FL] !== 1'b1 || busy_s[FL] !== 1'b0 || tx_s[FL] !== 1'b1) begin
            bad++; $display("FAIL known_done53: done=%b busy=%b tx=%b exp 1/0/1", done_s[FL], busy_s[FL], tx_s[FL]);
        end
        total++; if (done_s[FL + 1] !== 1'b0) begin
            bad++; $display("FAIL known_done54: got %b exp 0", done_s[FL + 1]);
        end
    endtask

    task automatic test_parity;
        logic [9:0]  fields [2];
        logic        par    [2];
        logic [10:0] w;
        fields[0] = 10'b0000_0000_00; par[0] = 1'b0;
        fields[1] = 10'b0001_0000_00; par[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            launch(fields[k][9:6], fields[k][5:2], fields[k][1:0]);
            capture(FL + 1, 1'b0, -1);
            w = rx_word(0);
            total++; if (w[0] !== par[k]) begin
                bad++; $display("FAIL parity_bit%0d: got %b exp %b", k, w[0], par[k]);
            end
            total++; if ((^w) !== 1'b0 || w[10:1] !== fields[k]) begin
                bad++; $display("FAIL parity_word%0d: got %h exp %h", k, w, {fields[k], par[k]});
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [10:0] w;
        int          dones;
        int          late_busy;
        int          txerr;
        logic [3:0]  r, f;
        logic [1:0]  o;
        r = 4'($urandom); f = 4'($urandom); o = 2'($urandom);
        w = exp_word(r, f, o);
        launch(r, f, o);
        capture(70, 1'b0, 19);
        dones = 0; late_busy = 0; txerr = 0;
        for (int i = 0; i < 70; i++) begin
            if (done_s[i] === 1'b1) dones++;
            if (i > FL && busy_s[i] !== 1'b0) late_busy++;
            if (i < FL && tx_s[i] !== exp_tx(w, i + 1)) txerr++;
        end
        total++; if (txerr != 0) begin bad++; $display("FAIL ignore_tx: got %0d bad bits exp 0", txerr); end
        total++; if (dones != 1 || done_s[FL] !== 1'b1) begin
            bad++; $display("FAIL ignore_done: got %0d pulses exp 1", dones);
        end
        total++; if (late_busy != 0) begin bad++; $display("FAIL ignore_second_frame: got %0d busy cycles exp 0", late_busy); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] w;
        int          err;
        int          dpos [$];
        logic [3:0]  r, f;
        logic [1:0]  o;
        r = 4'($urandom); f = 4'($urandom); o = 2'($urandom);
        w = exp_word(r, f, o);
        launch(r, f, o);
        capture(3 * (FL + 1), 1'b1, -1);
        err = 0;
        for (int i = 0; i < 3 * (FL + 1); i++) begin
            int c;
            c = i % (FL + 1);
            if (done_s[i] === 1'b1) dpos.push_back(i);
            if (c == FL) begin
                if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || done_s[i] !== 1'b1) err++;
            end else begin
                if (tx_s[i] !== exp_tx(w, c + 1) || busy_s[i] !== 1'b1 || done_s[i] !== 1'b0) err++;
            end
        end
        total++; if (err != 0) begin bad++; $display("FAIL b2b_cycles: got %0d bad cycles exp 0", err); end
        total++; if (dpos.size() != 3) begin
            bad++; $display("FAIL b2b_done_count: got %0d exp 3", dpos.size());
        end else if (dpos[1] - dpos[0] != FL + 1 || dpos[2] - dpos[1] != FL + 1) begin
            bad++; $display("FAIL b2b_done_spacing: got %0d,%0d exp %0d", dpos[1] - dpos[0], dpos[2] - dpos[1], FL + 1);
        end
        capture(3, 1'b0, -1);
        total++; if (busy_s[2] !== 1'b0) begin bad++; $display("FAIL b2b_no_fourth: got busy %b exp 0", busy_s[2]); end
    endtask

    task automatic test_reset_midframe;
        logic [10:0] w;
        int          dones;
        logic [3:0]  r, f;
        logic [1:0]  o;
        r = 4'($urandom); f = 4'($urandom); o = 2'($urandom);
        launch(r, f, o);
        capture(30, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midreset_async: tx=%b busy=%b done=%b exp 1/0/0", tx, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        r = 4'($urandom); f = 4'($urandom); o = 2'($urandom);
        w = exp_word(r, f, o);
        launch(r, f, o);
        capture(FL + 1, 1'b0, -1);
        dones = 0;
        for (int i = 0; i < FL; i++) if (done_s[i] === 1'b1) dones++;
        total++; if (dones != 0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses exp 0", dones); end
        total++; if (rx_word(0) !== w || tx_s[0] !== 1'b0 || done_s[FL] !== 1'b1) begin
            bad++; $display("FAIL midreset_next_frame: got %h exp %h", rx_word(0), w);
        end
    endtask

    task automatic test_random;
        logic [10:0] w;
        logic [3:0]  r, f;
        logic [1:0]  o;
        for (int k = 0; k < 200; k++) begin
            r = 4'($urandom); f = 4'($urandom); o = 2'($urandom);
            w = exp_word(r, f, o);
            launch(r, f, o);
            capture(FL + 1, 1'b0, int'($urandom_range(1, 40)));
            total++; if (rx_word(0) !== w) begin
                bad++; $display("FAIL random_word%0d: got %h exp %h", k, rx_word(0), w);
            end
            total++; if (busy_s[FL - 1] !== 1'b1 || busy_s[FL] !== 1'b0 || done_s[FL] !== 1'b1) begin
                bad++; $display("FAIL random_timing%0d: busy52=%b busy53=%b done53=%b", k, busy_s[FL - 1], busy_s[FL], done_s[FL]);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_parity();
        test_ignore_start();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
